// File: rtl/program_loader.sv
// Program-memory writer: streams bytes from a valid/ready source into RAM using the
// CPU's two-step bus protocol (mi then ri) while holding the CPU, then restarts it.
module program_loader #(
  parameter int WIDTH         = 8,
  parameter int ADDRESS_WIDTH = 4,
  parameter int ZERO_FILL     = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] mem_bus,
  output logic             mem_addr_enable,
  output logic             mem_write_enable,
  output logic             cpu_hold,
  output logic             cpu_restart,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_ADDR,
    S_DATA,
    S_FILL_ADDR,
    S_FILL_DATA,
    S_RELEASE,
    S_RUN
  } state_t;

  localparam logic [ADDRESS_WIDTH-1:0] ADDR_MAX  = '1;
  localparam bit                       FILL_TAIL = (ZERO_FILL != 0);

  state_t                   state;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [WIDTH-1:0]         data_reg;
  logic                     last_reg;

  // Every output is a register loaded with the value belonging to the state being
  // entered, so the strobes and bus line up exactly with the state they describe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_WAIT;
      addr             <= '0;
      data_reg         <= '0;
      last_reg         <= 1'b0;
      in_ready         <= 1'b1;
      mem_bus          <= '0;
      mem_addr_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      cpu_hold         <= 1'b1;
      cpu_restart      <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
    end else begin
      mem_addr_enable  <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_bus          <= '0;
      cpu_restart      <= 1'b0;

      case (state)
        S_WAIT: begin
          if (in_valid && in_ready) begin
            data_reg        <= in_data;
            last_reg        <= in_last;
            in_ready        <= 1'b0;
            mem_addr_enable <= 1'b1;
            mem_bus         <= WIDTH'(addr);
            state           <= S_ADDR;
          end
        end

        S_ADDR: begin
          mem_write_enable <= 1'b1;
          mem_bus          <= data_reg;
          state            <= S_DATA;
        end

        S_DATA: begin
          if (last_reg && (addr != ADDR_MAX) && FILL_TAIL) begin
            addr            <= addr + 1'b1;
            mem_addr_enable <= 1'b1;
            mem_bus         <= WIDTH'(addr + 1'b1);
            state           <= S_FILL_ADDR;
          end else if (last_reg) begin
            cpu_restart <= 1'b1;
            state       <= S_RELEASE;
          end else if (addr == ADDR_MAX) begin
            // Memory is full but the source has more: refuse the rest, never wrap.
            overflow    <= 1'b1;
            cpu_restart <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            addr     <= addr + 1'b1;
            in_ready <= 1'b1;
            state    <= S_WAIT;
          end
        end

        S_FILL_ADDR: begin
          mem_write_enable <= 1'b1;
          mem_bus          <= '0;
          state            <= S_FILL_DATA;
        end

        S_FILL_DATA: begin
          if (addr == ADDR_MAX) begin
            cpu_restart <= 1'b1;
            state       <= S_RELEASE;
          end else begin
            addr            <= addr + 1'b1;
            mem_addr_enable <= 1'b1;
            mem_bus         <= WIDTH'(addr + 1'b1);
            state           <= S_FILL_ADDR;
          end
        end

        S_RELEASE: begin
          done     <= 1'b1;
          cpu_hold <= 1'b0;
          state    <= S_RUN;
        end

        S_RUN: begin
          if (start) begin
            addr     <= '0;
            done     <= 1'b0;
            overflow <= 1'b0;
            cpu_hold <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_WAIT;
          end
        end

        default: state <= S_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: two instances (tail fill off / on) share one byte source;
// observed RAM writes are compared against a session-level model of the loader.
module tb_program_loader;
  localparam int W     = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         reset, start, in_valid, in_last;
  logic [W-1:0] in_data;

  logic         rdy[2], mi[2], ri[2], hold[2], rst_p[2], done[2], ovf[2];
  logic [W-1:0] bus[2];

  program_loader #(.WIDTH(W), .ADDRESS_WIDTH(AW), .ZERO_FILL(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[0]), .mem_bus(bus[0]), .mem_addr_enable(mi[0]),
    .mem_write_enable(ri[0]), .cpu_hold(hold[0]), .cpu_restart(rst_p[0]),
    .done(done[0]), .overflow(ovf[0]));

  program_loader #(.WIDTH(W), .ADDRESS_WIDTH(AW), .ZERO_FILL(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(rdy[1]), .mem_bus(bus[1]), .mem_addr_enable(mi[1]),
    .mem_write_enable(ri[1]), .cpu_hold(hold[1]), .cpu_restart(rst_p[1]),
    .done(done[1]), .overflow(ovf[1]));

  // Clock / reset block
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks   = 0;
  int failures = 0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Bus monitor: rebuilds each instance's RAM writes as {address, data} entries
  logic [AW-1:0] lat[2];
  logic          prev_rst[2] = '{1'b0, 1'b0};
  int            rst_cnt[2]     = '{0, 0};
  int            rst_cyc[2]     = '{0, 0};
  int            last_mi_cyc[2] = '{0, 0};
  logic [11:0]   log0[$], log1[$];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset === 1'b0) begin
        checks++;
        if (mi[i] && ri[i]) begin
          failures++;
          $display("FAIL strobe_overlap inst=%0d got mi=1 ri=1 exp=not both", i);
        end
        if (mi[i]) begin
          checks++;
          if (bus[i][W-1:AW] !== '0) begin
            failures++;
            $display("FAIL addr_zero_ext inst=%0d got=%0h exp=upper bits 0", i, bus[i]);
          end
          lat[i]         = bus[i][AW-1:0];
          last_mi_cyc[i] = cycle;
        end
        if (ri[i]) begin
          if (i == 0) log0.push_back({lat[i], bus[i]});
          else        log1.push_back({lat[i], bus[i]});
        end
        if (rst_p[i]) begin
          checks++;
          if (prev_rst[i] || !hold[i]) begin
            failures++;
            $display("FAIL restart_pulse inst=%0d got prev=%0b hold=%0b exp prev=0 hold=1",
                     i, prev_rst[i], hold[i]);
          end
          rst_cnt[i]++;
          rst_cyc[i] = cycle;
        end
        prev_rst[i] = rst_p[i];
      end else begin
        prev_rst[i] = 1'b0;
      end
    end
  end

  // Session stimulus and reference model
  logic [W-1:0] q_data[$];
  bit           q_last[$];
  logic [11:0]  exp_q[$];
  int           exp_acc;
  bit           exp_ovf;
  int           acc_cyc[$];

  // Words land at 0,1,2,... until a last byte (then optional zero tail) or the top
  // address is consumed by a non-last byte (overflow, further bytes refused).
  task automatic model(input bit zf);
    int a;
    exp_q.delete();
    exp_acc = 0;
    exp_ovf = 1'b0;
    a = 0;
    foreach (q_data[k]) begin
      exp_q.push_back({4'(a), q_data[k]});
      exp_acc++;
      if (q_last[k]) begin
        if (zf) for (int f = a + 1; f < DEPTH; f++) exp_q.push_back({4'(f), 8'h00});
        break;
      end
      if (a == DEPTH - 1) begin
        exp_ovf = 1'b1;
        break;
      end
      a++;
    end
  endtask

  // Driver: call just after a rising edge; returns just after the accepting edge.
  task automatic send_byte(input logic [W-1:0] d, input bit l, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    ok       = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      checks++;
      if (rdy[0] !== rdy[1]) begin
        failures++;
        $display("FAIL ready_lockstep got=%0b exp=%0b", rdy[1], rdy[0]);
      end
      if (rdy[0] === 1'b1) begin
        @(posedge clk);
        #1;
        ok = 1'b1;
        acc_cyc.push_back(cycle);
        return;
      end
    end
  endtask

  task automatic run_load(input string name, input int gap_after);
    int          base[2];
    int          n_acc;
    bit          ok;
    bit          finished;
    logic [11:0] got[$];
    log0.delete();
    log1.delete();
    acc_cyc.delete();
    base[0] = rst_cnt[0];
    base[1] = rst_cnt[1];
    n_acc   = 0;
    foreach (q_data[k]) begin
      send_byte(q_data[k], q_last[k], ok);
      if (!ok) break;
      n_acc++;
      if (k == gap_after) begin
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        for (int n = 0; n < 5; n++) begin
          @(negedge clk);
          for (int i = 0; i < 2; i++) begin
            checks++;
            if (mi[i] || ri[i] || !hold[i] || !rdy[i] ||
                (i == 0 ? dut0.addr : dut1.addr) !== 4'(gap_after + 1)) begin
              failures++;
              $display("FAIL %s.gap inst=%0d got mi=%0b ri=%0b hold=%0b rdy=%0b exp 0 0 1 1 addr=%0d",
                       name, i, mi[i], ri[i], hold[i], rdy[i], gap_after + 1);
            end
          end
        end
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    finished = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (hold[0] === 1'b0 && hold[1] === 1'b0) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished) begin
      failures++;
      $display("FAIL %s.release got hold=%0b%0b exp=00", name, hold[0], hold[1]);
    end
    @(posedge clk);
    #1;
    model(1'b0);
    checks++;
    if (n_acc != exp_acc) begin
      failures++;
      $display("FAIL %s.accepted got=%0d exp=%0d", name, n_acc, exp_acc);
    end
    for (int i = 0; i < 2; i++) begin
      model(i == 1);
      if (i == 0) got = log0;
      else        got = log1;
      checks++;
      if (got.size() != exp_q.size()) begin
        failures++;
        $display("FAIL %s.write_count inst=%0d got=%0d exp=%0d", name, i, got.size(), exp_q.size());
      end
      for (int k = 0; k < got.size() && k < exp_q.size(); k++) begin
        checks++;
        if (got[k] !== exp_q[k]) begin
          failures++;
          $display("FAIL %s.write inst=%0d idx=%0d got=%03h exp=%03h", name, i, k, got[k], exp_q[k]);
        end
      end
      checks++;
      if (done[i] !== 1'b1 || ovf[i] !== exp_ovf || hold[i] !== 1'b0 || rdy[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s.final inst=%0d got done=%0b ovf=%0b hold=%0b rdy=%0b exp 1 %0b 0 0",
                 name, i, done[i], ovf[i], hold[i], rdy[i], exp_ovf);
      end
      checks++;
      if (rst_cnt[i] - base[i] != 1 || rst_cyc[i] - last_mi_cyc[i] != 2) begin
        failures++;
        $display("FAIL %s.restart inst=%0d got pulses=%0d delay=%0d exp pulses=1 delay=2",
                 name, i, rst_cnt[i] - base[i], rst_cyc[i] - last_mi_cyc[i]);
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (done[i] !== 1'b0 || ovf[i] !== 1'b0 || hold[i] !== 1'b1 || rdy[i] !== 1'b1) begin
        failures++;
        $display("FAIL start inst=%0d got done=%0b ovf=%0b hold=%0b rdy=%0b exp 0 0 1 1",
                 i, done[i], ovf[i], hold[i], rdy[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string name);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (mi[i] !== 1'b0 || ri[i] !== 1'b0 || bus[i] !== '0 || rdy[i] !== 1'b1 ||
          hold[i] !== 1'b1 || rst_p[i] !== 1'b0 || done[i] !== 1'b0 || ovf[i] !== 1'b0 ||
          (i == 0 ? dut0.addr : dut1.addr) !== '0) begin
        failures++;
        $display("FAIL %s inst=%0d got mi=%0b ri=%0b bus=%0h rdy=%0b hold=%0b rst=%0b done=%0b ovf=%0b exp 0 0 0 1 1 0 0 0",
                 name, i, mi[i], ri[i], bus[i], rdy[i], hold[i], rst_p[i], done[i], ovf[i]);
      end
    end
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    q_data = '{8'h1E, 8'h2F, 8'h50};
    q_last = '{1'b0, 1'b0, 1'b1};
    run_load("basic", -1);
    for (int k = 1; k < acc_cyc.size(); k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] != 3) begin
        failures++;
        $display("FAIL basic.ready_period got=%0d exp=3", acc_cyc[k] - acc_cyc[k-1]);
      end
    end
  endtask

  task automatic test_restart_load();
    do_start();
    q_data = '{8'hF0};
    q_last = '{1'b1};
    run_load("restart_load", -1);
  endtask

  task automatic test_overflow();
    do_start();
    q_data.delete();
    q_last.delete();
    for (int k = 0; k < 17; k++) begin
      q_data.push_back(8'($urandom_range(0, 255)));
      q_last.push_back(1'b0);
    end
    run_load("overflow", -1);
  endtask

  task automatic test_gap();
    do_start();
    q_data = '{8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
    q_last = '{1'b0, 1'b0, 1'b1};
    run_load("gap", 0);
  endtask

  task automatic test_random();
    for (int s = 0; s < 5; s++) begin
      int len;
      do_start();
      len = (s == 0) ? DEPTH : $urandom_range(1, DEPTH);
      q_data.delete();
      q_last.delete();
      for (int k = 0; k < len; k++) begin
        q_data.push_back(8'($urandom_range(0, 255)));
        q_last.push_back(k == len - 1);
      end
      run_load($sformatf("random%0d", s), -1);
    end
  endtask

  task automatic test_reset_mid_write();
    bit ok;
    do_start();
    for (int k = 0; k < 4; k++) send_byte(8'(8'h40 + k), 1'b0, ok);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (ri[0] !== 1'b1 || ri[1] !== 1'b1) begin
      failures++;
      $display("FAIL mid_write.in_data got ri=%0b%0b exp=11", ri[0], ri[1]);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("mid_write_reset");
    @(posedge clk);
    #1;
    q_data = '{8'hA5, 8'h5A};
    q_last = '{1'b0, 1'b1};
    run_load("after_reset", -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_restart_load();
    test_overflow();
    test_gap();
    test_random();
    test_reset_mid_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
